trigger_capture_ctrl: RTL

Capture sequencer placed after the trigger block. It consumes the trigger block's output stream (sample data plus event bits) and drives the sample-buffer write port. It runs pre-trigger fill, waits for a trigger, counts post-trigger samples, then stops. It handles abort and stop, and reports the trigger position and done status. It is configured over the same write-only system bus used by the trigger block.

---
 rtl/trigger_capture_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/trigger_capture_ctrl.sv
// Capture sequencer: fills pre-trigger history, waits for a trigger, records the
// post-trigger window into the sample buffer, and reports position and status.
module trigger_capture_ctrl #(
    parameter int BAW = 6,
    parameter int BDW = 32,
    parameter int SDW = 32,
    parameter int SEW = 2,
    parameter int MAW = 10
) (
    input  logic           clk,
    input  logic           rst,
    output logic           bus_wready,
    input  logic           bus_wvalid,
    input  logic [BAW-1:0] bus_waddr,
    input  logic [BDW-1:0] bus_wdata,
    output logic           sti_tready,
    input  logic           sti_tvalid,
    input  logic [SEW-1:0] sti_tevent,
    input  logic [SDW-1:0] sti_tdata,
    output logic           mem_we,
    output logic [MAW-1:0] mem_waddr,
    output logic [SDW-1:0] mem_wdata,
    output logic [2:0]     sts_state,
    output logic [MAW-1:0] sts_trg_adr,
    output logic           sts_done,
    output logic           sts_abort,
    output logic           irq
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_WAIT = 3'd2,
        ST_POST = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t         state_r;
    logic [MAW-1:0] cfg_pre_r;
    logic [MAW-1:0] cfg_post_r;
    logic [MAW-1:0] work_pre_r;
    logic [MAW-1:0] work_post_r;
    logic [MAW-1:0] wptr_r;
    logic [MAW-1:0] cnt_r;
    logic [MAW-1:0] trg_adr_r;
    logic           mem_we_r;
    logic [MAW-1:0] mem_waddr_r;
    logic [SDW-1:0] mem_wdata_r;
    logic           done_r;
    logic           abort_r;
    logic           irq_r;

    logic           ctrl_wr_s;
    logic           stop_s;
    logic           arm_s;
    logic           trg_s;
    logic           abt_s;
    logic           capturing_s;
    logic [MAW:0]   cnt_inc_s;
    logic           bus_unused_s;

    // Stop outranks arm; any command also masks the stream sample of that cycle.
    assign ctrl_wr_s    = bus_wvalid && (bus_waddr[1:0] == 2'd0);
    assign stop_s       = ctrl_wr_s && bus_wdata[1];
    assign arm_s        = ctrl_wr_s && bus_wdata[0] && !bus_wdata[1];
    assign trg_s        = sti_tevent[0];
    assign abt_s        = sti_tevent[1];
    assign capturing_s  = (state_r == ST_PRE) || (state_r == ST_WAIT) || (state_r == ST_POST);
    assign cnt_inc_s    = {1'b0, cnt_r} + {{MAW{1'b0}}, 1'b1};
    assign bus_unused_s = ^{bus_waddr, bus_wdata, sti_tevent};

    assign bus_wready  = 1'b1;
    assign sti_tready  = 1'b1;
    assign mem_we      = mem_we_r;
    assign mem_waddr   = mem_waddr_r;
    assign mem_wdata   = mem_wdata_r;
    assign sts_state   = state_r;
    assign sts_trg_adr = trg_adr_r;
    assign sts_done    = done_r;
    assign sts_abort   = abort_r;
    assign irq         = irq_r;

    // Configuration registers, capture sequencer and registered buffer write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cfg_pre_r   <= {MAW{1'b0}};
            cfg_post_r  <= {MAW{1'b0}};
            work_pre_r  <= {MAW{1'b0}};
            work_post_r <= {MAW{1'b0}};
            wptr_r      <= {MAW{1'b0}};
            cnt_r       <= {MAW{1'b0}};
            trg_adr_r   <= {MAW{1'b0}};
            mem_we_r    <= 1'b0;
            mem_waddr_r <= {MAW{1'b0}};
            mem_wdata_r <= {SDW{1'b0}};
            done_r      <= 1'b0;
            abort_r     <= 1'b0;
            irq_r       <= 1'b0;
        end else begin
            mem_we_r <= 1'b0;
            irq_r    <= 1'b0;

            if (bus_wvalid) begin
                case (bus_waddr[1:0])
                    2'd1:    cfg_pre_r  <= bus_wdata[MAW-1:0];
                    2'd2:    cfg_post_r <= bus_wdata[MAW-1:0];
                    default: ;
                endcase
            end

            if (stop_s) begin
                state_r <= ST_IDLE;
                done_r  <= 1'b0;
            end else if (arm_s) begin
                wptr_r      <= {MAW{1'b0}};
                cnt_r       <= {MAW{1'b0}};
                abort_r     <= 1'b0;
                done_r      <= 1'b0;
                work_pre_r  <= cfg_pre_r;
                work_post_r <= cfg_post_r;
                state_r     <= (cfg_pre_r == {MAW{1'b0}}) ? ST_WAIT : ST_PRE;
            end else if (sti_tvalid && capturing_s) begin
                if (abt_s) begin
                    state_r <= ST_IDLE;
                    abort_r <= 1'b1;
                end else begin
                    mem_we_r    <= 1'b1;
                    mem_waddr_r <= wptr_r;
                    mem_wdata_r <= sti_tdata;
                    wptr_r      <= wptr_r + MAW'(1);
                    case (state_r)
                        ST_PRE: begin
                            cnt_r <= cnt_inc_s[MAW-1:0];
                            if (cnt_inc_s == {1'b0, work_pre_r}) begin
                                state_r <= ST_WAIT;
                            end
                        end
                        ST_WAIT: begin
                            if (trg_s) begin
                                trg_adr_r <= wptr_r;
                                cnt_r     <= {MAW{1'b0}};
                                if (work_post_r == {MAW{1'b0}}) begin
                                    state_r <= ST_DONE;
                                    done_r  <= 1'b1;
                                    irq_r   <= 1'b1;
                                end else begin
                                    state_r <= ST_POST;
                                end
                            end
                        end
                        ST_POST: begin
                            cnt_r <= cnt_inc_s[MAW-1:0];
                            if (cnt_inc_s == {1'b0, work_post_r}) begin
                                state_r <= ST_DONE;
                                done_r  <= 1'b1;
                                irq_r   <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
